// File: rtl/vga_hif_pkg.sv
// rtl/vga_hif_pkg.sv - shared types and constants for the VGA host-interface cycle generator
//
// Purpose: FSM state encoding, default claimed I/O window, error read pattern,
// the 61-bit queued request layout and the I/O claim decode helper.
package vga_hif_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RECOV = 2'd2
  } state_t;

  localparam logic [15:0] IO_LO_DEF = 16'h03B0;
  localparam logic [15:0] IO_HI_DEF = 16'h03DF;
  localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

  // 23 + 4 + 1 + 1 + 32 = 61 bits
  typedef struct packed {
    logic [22:0] addr;
    logic [3:0]  be_n;
    logic        mem_io_n;
    logic        rd_wr_n;
    logic [31:0] wdata;
  } req_t;

  // Memory space is always ours; I/O only inside the low 64K window [lo, hi].
  function automatic logic is_claimed(input logic [22:0] addr, input logic mem_io_n,
                                      input logic [15:0] lo, input logic [15:0] hi);
    if (mem_io_n) return 1'b1;
    return (addr[22:16] == 7'd0) && (addr[15:0] >= lo) && (addr[15:0] <= hi);
  endfunction

endpackage

// File: rtl/hif_req_fifo.sv
// rtl/hif_req_fifo.sv - synchronous request queue with full/empty flags
//
// Purpose: DEPTH-entry FIFO (DEPTH a power of 2) using read/write pointers with
// one extra wrap bit, so full and empty are told apart without a counter.
// Ports:
//   i_clk, i_rst      clock, asynchronous active-high reset (empties queue)
//   i_push, i_wdata   write strobe and data (ignored when full)
//   i_pop             read strobe (ignored when empty)
//   o_rdata           head entry (valid when !o_empty)
//   o_full, o_empty   status flags
module hif_req_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned WIDTH = 61
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_do_push;
  logic             w_do_pop;

  // Same index, different lap: writer is a full lap ahead.
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/hif_cyc_gen.sv
// rtl/hif_cyc_gen.sv - turns queued host requests into single VGA t_* bus cycles
//
// Purpose: accepts host requests into a small queue, decodes ownership of the
// head, runs one VGA cycle at a time (IDLE -> WAIT -> RECOV), waits for
// h_t_ready_n with a timeout, and returns one response pulse per request in order.
// Ports:
//   h_hclk, h_reset          clock, asynchronous active-high reset
//   req_*                    host request port (valid/ready)
//   rsp_valid/rdata/err      one-cycle response, no backpressure
//   t_*                      registered cycle outputs to the VGA host interface
//   t_hdata_out, h_t_ready_n read data and completion strobe from the VGA side
//   busy                     cycle in progress or requests queued
module hif_cyc_gen
  import vga_hif_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [15:0] IO_LO      = IO_LO_DEF,
  parameter logic [15:0] IO_HI      = IO_HI_DEF
) (
  input  logic        h_hclk,
  input  logic        h_reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [22:0] req_addr,
  input  logic [3:0]  req_be_n,
  input  logic        req_mem_io_n,
  input  logic        req_rd_wr_n,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [22:0] t_haddr,
  output logic [3:0]  t_byte_en_n,
  output logic        t_mem_io_n,
  output logic        t_hrd_hwr_n,
  output logic        t_svga_sel,
  output logic [31:0] t_hdata_in,
  input  logic [31:0] t_hdata_out,
  input  logic        h_t_ready_n,
  output logic        busy
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t     r_state;
  logic [7:0] r_cnt;
  req_t       w_push_req;
  req_t       w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_claim;
  logic       w_timeout;
  logic       w_pop;

  assign w_push_req = {req_addr, req_be_n, req_mem_io_n, req_rd_wr_n, req_wdata};
  assign req_ready  = !w_full;
  assign busy       = (r_state != IDLE) || !w_empty;
  assign w_claim    = is_claimed(w_head.addr, w_head.mem_io_n, IO_LO, IO_HI);
  assign w_timeout  = (r_cnt == TIMEOUT_CNT);

  // The head leaves the queue only when its response is issued.
  assign w_pop = ((r_state == IDLE) && !w_empty && !w_claim) ||
                 ((r_state == WAIT) && (!h_t_ready_n || w_timeout));

  hif_req_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(req_t))
  ) u_fifo (
    .i_clk   (h_hclk),
    .i_rst   (h_reset),
    .i_push  (req_valid && !w_full),
    .i_wdata (w_push_req),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge h_hclk or posedge h_reset) begin
    if (h_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      t_svga_sel  <= 1'b0;
      t_hrd_hwr_n <= 1'b1;
      t_mem_io_n  <= 1'b1;
      t_byte_en_n <= 4'hF;
      t_haddr     <= '0;
      t_hdata_in  <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (!w_empty) begin
            if (w_claim) begin
              t_haddr     <= w_head.addr;
              t_byte_en_n <= w_head.be_n;
              t_mem_io_n  <= w_head.mem_io_n;
              t_hrd_hwr_n <= w_head.rd_wr_n;
              t_hdata_in  <= w_head.wdata;
              t_svga_sel  <= 1'b1;
              r_cnt       <= '0;
              r_state     <= WAIT;
            end else begin
              // Nobody decodes this address: fail it without touching the bus.
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              rsp_rdata <= ERR_RDATA;
              r_state   <= RECOV;
            end
          end
        end
        WAIT: begin
          // Ready is checked first so a completion on the timeout edge is not lost.
          if (!h_t_ready_n) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b0;
            rsp_rdata   <= t_hrd_hwr_n ? t_hdata_out : 32'd0;
            t_svga_sel  <= 1'b0;
            t_hrd_hwr_n <= 1'b1;
            r_state     <= RECOV;
          end else if (w_timeout) begin
            rsp_valid   <= 1'b1;
            rsp_err     <= 1'b1;
            rsp_rdata   <= ERR_RDATA;
            t_svga_sel  <= 1'b0;
            t_hrd_hwr_n <= 1'b1;
            r_state     <= RECOV;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        RECOV:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/hif_cyc_gen.md
Name: hif_cyc_gen

Overview:
- Upstream stage of the VGA host interface: takes host bus requests from a valid/ready port and turns each into one VGA cycle on the t_* bus.
- Decodes VGA I/O ownership, runs one cycle at a time, and waits for h_t_ready_n.
- Returns read data or an error response, and bounds every cycle with a timeout.
- Holds a small request queue so the host can post back-to-back writes.

Parameters:
- FIFO_DEPTH, 2, request queue entries (power of 2, ≥2)
- TIMEOUT, 255, WAIT cycles before abort (8-bit counter)
- IO_LO, 16'h03B0, lowest claimed I/O address
- IO_HI, 16'h03DF, highest claimed I/O address

Ports:
- h_hclk  in  1  host/memory clock, all logic on rising edge
- h_reset  in  1  reset; asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  queue not full
- req_addr  in  23  byte address
- req_be_n  in  4  byte enables, active low
- req_mem_io_n  in  1  1=memory, 0=I/O
- req_rd_wr_n  in  1  1=read, 0=write
- req_wdata  in  32  write data
- rsp_valid  out  1  one-cycle response pulse, no backpressure
- rsp_rdata  out  32  read data (writes return 0)
- rsp_err  out  1  unclaimed or timed out
- t_haddr  out  23  to VGA host interface
- t_byte_en_n  out  4  to VGA host interface
- t_mem_io_n  out  1  to VGA host interface
- t_hrd_hwr_n  out  1  to VGA host interface
- t_svga_sel  out  1  cycle valid/claimed
- t_hdata_in  out  32  write data to VGA
- t_hdata_out  in  32  read data from VGA
- h_t_ready_n  in  1  VGA cycle complete, active low
- busy  out  1  FSM not IDLE or queue non-empty

Behaviour:
- Reset (async, any state):
  - FIFO emptied; FSM to IDLE; timeout counter 0.
  - Outputs: t_svga_sel=0, t_hrd_hwr_n=1, t_mem_io_n=1, t_byte_en_n=4'hF, t_haddr=0, t_hdata_in=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, req_ready=1.
  - A cycle in flight is dropped with no response.
- Queue:
  - Push when req_valid&req_ready; req_ready = !full.
  - Pop only on FSM completion.
  - Push and pop on the same edge is allowed when not full; count stays the same.
  - When full, req_ready=0 even if a pop happens on the same edge.
- Claim decode (on the FIFO head):
  - Memory requests are always claimed.
  - I/O requests are claimed iff addr[22:16]==0 and IO_LO ≤ addr[15:0] ≤ IO_HI.
- FSM states: IDLE, WAIT, RECOV.
- IDLE, queue non-empty, claimed head:
  - Register the head onto the t_* outputs and set t_svga_sel=1.
  - Clear the counter; go to WAIT.
- IDLE, queue non-empty, unclaimed head:
  - Pop; pulse rsp_valid with rsp_err=1 and rsp_rdata=32'hFFFF_FFFF.
  - t_svga_sel stays 0; go to RECOV.
- WAIT:
  - t_* outputs are held stable.
  - If h_t_ready_n=0 at an edge:
    - rsp_rdata = reads ? t_hdata_out : 0; rsp_err=0; rsp_valid=1 for one cycle.
    - t_svga_sel=0, t_hrd_hwr_n=1; pop; go to RECOV.
  - Otherwise, if counter==TIMEOUT: same exit, but rsp_err=1 and rsp_rdata=32'hFFFF_FFFF.
  - Otherwise the counter increments.
  - If ready and timeout coincide, ready wins.
- RECOV: one idle cycle with t_svga_sel=0, guaranteeing a deselect gap between cycles; then IDLE.
- Latency:
  - Push at edge E0 into an empty queue with FSM in IDLE → t_svga_sel high after E1.
  - h_t_ready_n low sampled at Ek → rsp_valid high after Ek.
  - Minimum request-to-response is 3 edges; back-to-back cycles are spaced ≥3 cycles apart.
- The t_* outputs change only at IDLE→WAIT and at WAIT exit.
- h_t_ready_n is ignored outside WAIT.
- Response ordering equals request order.

Decomposition:
- Package vga_hif_pkg:
  - FSM state enum (IDLE/WAIT/RECOV).
  - IO_LO/IO_HI defaults.
  - Error read pattern 32'hFFFF_FFFF.
  - Request struct packing {addr, be_n, mem_io_n, rd_wr_n, wdata}, 61 bits.
- Sub-module hif_req_fifo: synchronous FIFO with full/empty, FIFO_DEPTH entries, pointer wrap via extra MSB.

Test Plan:
- I/O write 0x03C4, be_n=4'hE, data 0x0000_0002; ready low 2 cycles after select → t_svga_sel high 2 cycles then low; one rsp_valid with rsp_err=0, rsp_rdata=0.
- Memory read 0x0A0000; VGA returns 0xDEAD_BEEF with h_t_ready_n low → rsp_rdata=0xDEAD_BEEF, rsp_err=0; deselect gap of 1 cycle seen.
- I/O read 0x0300 (unclaimed) → t_svga_sel never asserts; rsp_err=1, rsp_rdata=0xFFFF_FFFF two edges after push.
- Claimed read with h_t_ready_n held high → abort after TIMEOUT+1 WAIT edges; rsp_err=1.
  - Second run drives ready low on exactly the timeout edge → rsp_err=0.
- Three posted writes pushed on consecutive cycles with FIFO_DEPTH=2 → req_ready drops after the second push; all three complete in order with a RECOV gap between selects.
- Assert h_reset during WAIT → all outputs go to reset values immediately; no rsp_valid; busy=0; a new request after release completes normally.
